// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, states,
// write-back selects and branch funct3 values.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] WS_ALU = 2'b00;
  localparam logic [1:0] WS_MEM = 2'b01;
  localparam logic [1:0] WS_PC4 = 2'b10;
  localparam logic [1:0] WS_IMM = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the I/S/B/U/J field layout from the opcode and
// sign-extends the result to XLEN.
module imm_gen
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    case (ir[6:0])
      // shift-immediates carry only the 5-bit shamt; funct7 must not leak in
      OP_IMM:           raw = (ir[13:12] == 2'b01) ? {27'd0, ir[24:20]}
                                                   : {{20{ir[31]}}, ir[31:20]};
      OP_LOAD, OP_JALR: raw = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:         raw = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:        raw = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC: raw = {ir[31:12], 12'd0};
      OP_JAL:           raw = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:          raw = '0;
    endcase
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: sequences each instruction with ready
// handshakes to instruction/data memory and drives all datapath selects.
//
// state  | meaning
// FETCH  | request instruction, latch ir on imem_ready
// DECODE | latch immediate, check opcode
// EXEC   | drive ALU selects, resolve branches
// MEM    | data access held until dmem_ready
// WB     | register write and PC update
// TRAP   | illegal opcode seen, halted until reset
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_IR = 32'h0000_0013,
  parameter bit          EN_TRAP  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic            eq,
  input  logic            lt,
  input  logic            ltu,
  output logic            imem_req,
  output logic            dmem_req,
  output logic [31:0]     ir,
  output logic [XLEN-1:0] imm,
  output logic            data_a_sel,
  output logic            data_b_sel,
  output logic            pc_we,
  output logic            pc_sel,
  output logic            reg_we,
  output logic [1:0]      write_sel,
  output logic [3:0]      alu_mode,
  output logic [3:0]      ram_mode,
  output logic            illegal,
  output logic [2:0]      state_dbg
);

  state_t          state, state_nx;
  logic [XLEN-1:0] imm_nx;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            is_store, is_mem, taken;

  assign opcode    = ir[6:0];
  assign f3        = ir[14:12];
  assign is_store  = (opcode == OP_STORE);
  assign is_mem    = (opcode == OP_LOAD) || is_store;
  assign state_dbg = state;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ir  (ir),
    .imm (imm_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      ir      <= RESET_IR;
      imm     <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FETCH && imem_ready) ir <= imem_rdata;
      if (state == DECODE) imm <= imm_nx;
      if (state_nx == TRAP) illegal <= 1'b1;
    end
  end

  always_comb begin
    case (f3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    reg_we     = 1'b0;
    write_sel  = WS_ALU;
    data_a_sel = 1'b0;
    data_b_sel = 1'b0;
    alu_mode   = 4'd0;
    ram_mode   = 4'd0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nx = DECODE;
      end
      DECODE: begin
        if (is_legal(opcode)) begin
          state_nx = EXEC;
        end else if (EN_TRAP) begin
          state_nx = TRAP;
        end else begin
          pc_we    = 1'b1;
          state_nx = FETCH;
        end
      end
      EXEC: begin
        if (opcode == OP_BRANCH) begin
          pc_we    = 1'b1;
          pc_sel   = taken;
          state_nx = FETCH;
        end else begin
          state_nx = is_mem ? MEM : WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we    = 1'b1;
            state_nx = FETCH;
          end else begin
            state_nx = WB;
          end
        end
      end
      WB: begin
        reg_we   = (ir[11:7] != 5'd0);
        pc_we    = 1'b1;
        pc_sel   = (opcode == OP_JAL) || (opcode == OP_JALR);
        state_nx = FETCH;
        case (opcode)
          OP_LOAD:         write_sel = WS_MEM;
          OP_JAL, OP_JALR: write_sel = WS_PC4;
          OP_LUI:          write_sel = WS_IMM;
          default:         write_sel = WS_ALU;
        endcase
      end
      TRAP:    state_nx = TRAP;
      default: state_nx = FETCH;
    endcase

    // datapath selects depend only on ir, so they stay put from EXEC to WB
    if (state inside {EXEC, MEM, WB}) begin
      case (opcode)
        OP_R:   alu_mode = {f3, ir[30]};
        OP_IMM: begin
          alu_mode   = {f3, (f3 == 3'b101) ? ir[30] : 1'b0};
          data_b_sel = 1'b1;
        end
        OP_LOAD, OP_STORE: begin
          data_b_sel = 1'b1;
          ram_mode   = {f3, is_store};
        end
        OP_JALR: data_b_sel = 1'b1;
        OP_AUIPC, OP_JAL, OP_BRANCH: begin
          data_a_sel = 1'b1;
          data_b_sel = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// legal instructions checked against an instruction-level reference model.
module tb_multicycle_control;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
                         ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5;
  localparam logic [6:0] OPC_R = 7'b0110011, OPC_IMM = 7'b0010011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_BR = 7'b1100011, OPC_JALR = 7'b1100111,
                         OPC_JAL = 7'b1101111, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;
  localparam int MAXC = 64;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, eq = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic        imem_req, dmem_req, data_a_sel, data_b_sel, pc_we, pc_sel, reg_we, illegal;
  logic [31:0] ir, imm;
  logic [1:0]  write_sel;
  logic [3:0]  alu_mode, ram_mode;
  logic [2:0]  state_dbg;

  int errors = 0, checks = 0;

  logic [6:0] ops [9] = '{OPC_R, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_BR,
                          OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC};

  logic [2:0] t_st [MAXC];
  logic       t_pcwe [MAXC], t_regwe [MAXC], t_pcsel [MAXC], t_ireq [MAXC], t_dreq [MAXC];
  logic       t_asel [MAXC], t_bsel [MAXC];
  logic [1:0] t_wsel [MAXC];
  logic [3:0] t_alu [MAXC], t_ram [MAXC];
  int         t_len;
  bit         t_timeout;

  always #5 clk = ~clk;

  multicycle_control #(.XLEN(32), .RESET_IR(32'h0000_0013), .EN_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .eq(eq), .lt(lt), .ltu(ltu), .imem_req(imem_req),
    .dmem_req(dmem_req), .ir(ir), .imm(imm), .data_a_sel(data_a_sel),
    .data_b_sel(data_b_sel), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .write_sel(write_sel), .alu_mode(alu_mode), .ram_mode(ram_mode),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  // ---------------- reference model (instruction level) ----------------
  function automatic bit m_is_mem(input logic [31:0] i);
    return (i[6:0] == OPC_LOAD) || (i[6:0] == OPC_STORE);
  endfunction

  // cycles after the fetch cycle(s) until the next fetch begins
  function automatic int m_body_len(input logic [31:0] i, input int mw);
    case (i[6:0])
      OPC_BR:    return 2;
      OPC_LOAD:  return 3 + mw + 1;
      OPC_STORE: return 2 + mw + 1;
      default:   return 3;
    endcase
  endfunction

  function automatic bit m_taken(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    case (i[14:12])
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_writes(input logic [31:0] i);
    return (i[6:0] != OPC_BR) && (i[6:0] != OPC_STORE) && (i[11:7] != 5'd0);
  endfunction

  function automatic logic [1:0] m_wsel(input logic [31:0] i);
    if (i[6:0] == OPC_LOAD) return 2'b01;
    if (i[6:0] == OPC_JAL || i[6:0] == OPC_JALR) return 2'b10;
    if (i[6:0] == OPC_LUI) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic m_pcsel(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    if (i[6:0] == OPC_BR) return m_taken(i, a, b);
    return (i[6:0] == OPC_JAL) || (i[6:0] == OPC_JALR);
  endfunction

  function automatic logic [3:0] m_alu(input logic [31:0] i);
    if (i[6:0] == OPC_R) return {i[14:12], i[30]};
    if (i[6:0] == OPC_IMM) return {i[14:12], (i[14:12] == 3'd5) ? i[30] : 1'b0};
    return 4'd0;
  endfunction

  function automatic logic m_asel(input logic [31:0] i);
    return (i[6:0] == OPC_AUIPC) || (i[6:0] == OPC_JAL) || (i[6:0] == OPC_BR);
  endfunction

  function automatic logic m_bsel(input logic [31:0] i);
    return (i[6:0] != OPC_R) && (i[6:0] != OPC_LUI);
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    logic [11:0] s12;
    logic [12:0] b13;
    logic [20:0] j21;
    s12 = {i[31:25], i[11:7]};
    b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    case (i[6:0])
      OPC_IMM:             return (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 32'(i[24:20])
                                                                         : 32'($signed(i[31:20]));
      OPC_LOAD, OPC_JALR:  return 32'($signed(i[31:20]));
      OPC_STORE:           return 32'($signed(s12));
      OPC_BR:              return 32'($signed(b13));
      OPC_LUI, OPC_AUIPC:  return i & 32'hFFFF_F000;
      OPC_JAL:             return 32'($signed(j21));
      default:             return 32'd0;
    endcase
  endfunction

  function automatic int count_of(input int which);
    int c = 0;
    for (int k = 0; k < t_len; k++) begin
      case (which)
        0:       c += int'(t_pcwe[k]);
        1:       c += int'(t_regwe[k]);
        2:       c += int'(t_dreq[k]);
        default: c += int'(t_ireq[k]);
      endcase
    end
    return c;
  endfunction

  // Drive one instruction through the unit and record every cycle; ready
  // lines carry random noise outside the states that are allowed to use them.
  task automatic run(input logic [31:0] instr, input int fwait, input int mwait,
                     input logic [31:0] a, input logic [31:0] b);
    int fcnt = 0, mcnt = 0;
    logic [2:0] s;
    t_len = 0;
    t_timeout = 1'b0;
    eq  = (a == b);
    lt  = ($signed(a) < $signed(b));
    ltu = (a < b);
    forever begin
      s = state_dbg;
      imem_ready = (s == ST_FETCH) ? (fcnt >= fwait) : 1'($urandom);
      imem_rdata = (s == ST_FETCH && fcnt >= fwait) ? instr : $urandom;
      dmem_ready = (s == ST_MEM) ? (mcnt >= mwait) : 1'($urandom);
      @(negedge clk);
      t_st[t_len] = state_dbg;  t_pcwe[t_len] = pc_we;   t_regwe[t_len] = reg_we;
      t_pcsel[t_len] = pc_sel;  t_ireq[t_len] = imem_req; t_dreq[t_len] = dmem_req;
      t_asel[t_len] = data_a_sel; t_bsel[t_len] = data_b_sel; t_wsel[t_len] = write_sel;
      t_alu[t_len] = alu_mode;  t_ram[t_len] = ram_mode;
      @(posedge clk);
      #1;
      if (s == ST_FETCH) fcnt++;
      if (s == ST_MEM) mcnt++;
      t_len++;
      if (s == ST_TRAP) break;
      if (state_dbg == ST_FETCH && s != ST_FETCH) break;
      if (t_len >= MAXC) begin
        t_timeout = 1'b1;
        break;
      end
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (state_dbg !== ST_FETCH || ir !== 32'h13 || imm !== 32'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: state=%0d ir=%h imm=%h illegal=%b want 0/00000013/0/0",
               state_dbg, ir, imm, illegal);
    end
    checks++;
    if ({pc_we, reg_we, dmem_req, pc_sel, data_a_sel, data_b_sel} !== 6'd0 ||
        write_sel !== 2'd0 || alu_mode !== 4'd0 || ram_mode !== 4'd0) begin
      errors++;
      $display("FAIL reset_outs: strobes/selects=%b ws=%b alu=%b ram=%b want all 0",
               {pc_we, reg_we, dmem_req, pc_sel, data_a_sel, data_b_sel}, write_sel, alu_mode, ram_mode);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b1 || state_dbg !== ST_FETCH) begin
      errors++;
      $display("FAIL reset_fetch: imem_req=%b state=%0d want 1/0", imem_req, state_dbg);
    end
  endtask

  task automatic test_add();
    run(32'h0020_81B3, 0, 0, 32'd5, 32'd9);
    checks++;
    if (t_timeout || t_len != 4) begin
      errors++;
      $display("FAIL add_len: got %0d cycles (timeout=%0b) want 4", t_len, t_timeout);
    end
    checks++;
    if (t_alu[2] !== 4'b0000 || t_st[3] !== ST_WB) begin
      errors++;
      $display("FAIL add_alu: alu=%b wb_state=%0d want 0000/4", t_alu[2], t_st[3]);
    end
    checks++;
    if (count_of(1) != 1 || t_regwe[3] !== 1'b1 || t_wsel[3] !== 2'b00) begin
      errors++;
      $display("FAIL add_wb: reg_we count=%0d last=%b ws=%b want 1/1/00", count_of(1), t_regwe[3], t_wsel[3]);
    end
    checks++;
    if (count_of(0) != 1 || t_pcwe[3] !== 1'b1 || t_pcsel[3] !== 1'b0) begin
      errors++;
      $display("FAIL add_pc: pc_we count=%0d last=%b pc_sel=%b want 1/1/0", count_of(0), t_pcwe[3], t_pcsel[3]);
    end
  endtask

  task automatic test_shift_imm();
    run(32'h4033_5293, 0, 0, 32'd0, 32'd0);
    checks++;
    if (t_alu[2] !== 4'b1011 || imm !== 32'd3 || !t_bsel[2]) begin
      errors++;
      $display("FAIL srai: alu=%b imm=%h bsel=%b want 1011/00000003/1", t_alu[2], imm, t_bsel[2]);
    end
    run(32'hFFF0_0093, 1, 0, 32'd0, 32'd0);
    checks++;
    if (t_alu[3] !== 4'b0000 || imm !== 32'hFFFF_FFFF || t_len != 5) begin
      errors++;
      $display("FAIL addi_neg: alu=%b imm=%h len=%0d want 0000/ffffffff/5", t_alu[3], imm, t_len);
    end
  endtask

  task automatic test_load();
    run(32'h0081_2203, 0, 3, 32'd0, 32'd0);
    checks++;
    if (t_timeout || t_len != 8 || count_of(2) != 4) begin
      errors++;
      $display("FAIL lw_mem: len=%0d dmem_req cycles=%0d want 8/4", t_len, count_of(2));
    end
    checks++;
    if (t_ram[3] !== 4'b0100 || t_ram[6] !== 4'b0100) begin
      errors++;
      $display("FAIL lw_ram_mode: got %b/%b want 0100", t_ram[3], t_ram[6]);
    end
    checks++;
    if (count_of(1) != 1 || t_regwe[7] !== 1'b1 || t_wsel[7] !== 2'b01 ||
        t_wsel[6] !== 2'b00 || t_st[7] !== ST_WB) begin
      errors++;
      $display("FAIL lw_wb: reg_we count=%0d last=%b ws=%b prev_ws=%b want 1/1/01/00",
               count_of(1), t_regwe[7], t_wsel[7], t_wsel[6]);
    end
  endtask

  task automatic test_branch();
    run(32'h00A5_F463, 0, 0, 32'd1, 32'd2);
    checks++;
    if (t_len != 3 || t_pcwe[2] !== 1'b1 || t_pcsel[2] !== 1'b0 || count_of(1) != 0) begin
      errors++;
      $display("FAIL bgeu_not_taken: len=%0d pc_we=%b pc_sel=%b reg_we=%0d want 3/1/0/0",
               t_len, t_pcwe[2], t_pcsel[2], count_of(1));
    end
    run(32'h00A5_F463, 0, 0, 32'd2, 32'd1);
    checks++;
    if (t_len != 3 || t_pcwe[2] !== 1'b1 || t_pcsel[2] !== 1'b1 || t_st[2] !== ST_EXEC) begin
      errors++;
      $display("FAIL bgeu_taken: len=%0d pc_we=%b pc_sel=%b state=%0d want 3/1/1/2",
               t_len, t_pcwe[2], t_pcsel[2], t_st[2]);
    end
  endtask

  task automatic test_x0();
    run(32'h0050_0013, 0, 0, 32'd0, 32'd0);
    checks++;
    if (count_of(1) != 0 || count_of(0) != 1) begin
      errors++;
      $display("FAIL addi_x0: reg_we count=%0d pc_we count=%0d want 0/1", count_of(1), count_of(0));
    end
  endtask

  task automatic test_random();
    logic [31:0] instr, a, b;
    int fw, mw, last, bad;
    for (int n = 0; n < 40; n++) begin
      instr = $urandom;
      instr[6:0] = ops[$urandom_range(0, 8)];
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run(instr, fw, mw, a, b);
      last = t_len - 1;
      checks++;
      if (t_timeout || t_len != fw + 1 + m_body_len(instr, mw)) begin
        errors++;
        $display("FAIL rnd_len[%0d] %h: got %0d want %0d", n, instr, t_len, fw + 1 + m_body_len(instr, mw));
        continue;
      end
      checks++;
      if (count_of(0) != 1 || t_pcwe[last] !== 1'b1 || t_pcsel[last] !== m_pcsel(instr, a, b)) begin
        errors++;
        $display("FAIL rnd_pc[%0d] %h: pc_we count=%0d last=%b pc_sel=%b want 1/1/%b",
                 n, instr, count_of(0), t_pcwe[last], t_pcsel[last], m_pcsel(instr, a, b));
      end
      checks++;
      if (count_of(1) != int'(m_writes(instr)) || (m_writes(instr) && t_regwe[last] !== 1'b1)) begin
        errors++;
        $display("FAIL rnd_regwe[%0d] %h: count=%0d want %0d", n, instr, count_of(1), int'(m_writes(instr)));
      end
      if (m_writes(instr)) begin
        checks++;
        if (t_wsel[last] !== m_wsel(instr)) begin
          errors++;
          $display("FAIL rnd_wsel[%0d] %h: got %b want %b", n, instr, t_wsel[last], m_wsel(instr));
        end
      end
      bad = 0;
      for (int k = fw + 2; k < t_len; k++)
        if (t_alu[k] !== m_alu(instr) || t_asel[k] !== m_asel(instr) || t_bsel[k] !== m_bsel(instr)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rnd_sel[%0d] %h: alu=%b a=%b b=%b want %b/%b/%b in %0d cycles", n, instr,
                 t_alu[last], t_asel[last], t_bsel[last], m_alu(instr), m_asel(instr), m_bsel(instr), bad);
      end
      checks++;
      if (count_of(3) != fw + 1 || count_of(2) != (m_is_mem(instr) ? mw + 1 : 0)) begin
        errors++;
        $display("FAIL rnd_req[%0d] %h: imem_req=%0d dmem_req=%0d want %0d/%0d", n, instr,
                 count_of(3), count_of(2), fw + 1, m_is_mem(instr) ? mw + 1 : 0);
      end
      if (m_is_mem(instr)) begin
        bad = 0;
        for (int k = fw + 3; k < fw + 3 + mw + 1; k++)
          if (t_ram[k] !== {instr[14:12], instr[6:0] == OPC_STORE}) bad++;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL rnd_ram[%0d] %h: got %b want %b", n, instr, t_ram[fw + 3],
                   {instr[14:12], instr[6:0] == OPC_STORE});
        end
      end
      checks++;
      if (imm !== m_imm(instr) || ir !== instr) begin
        errors++;
        $display("FAIL rnd_imm_ir[%0d]: imm=%h ir=%h want %h/%h", n, imm, ir, m_imm(instr), instr);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    int n = 0;
    imem_rdata = 32'h0081_2203;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    while (state_dbg != ST_MEM && n < 20) begin
      @(posedge clk);
      #1;
      imem_ready = (state_dbg == ST_FETCH);
      n++;
    end
    imem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== ST_MEM || dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL midmem_reach: state=%0d dmem_req=%b want 3/1", state_dbg, dmem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || ir !== 32'h13 || state_dbg !== ST_FETCH) begin
      errors++;
      $display("FAIL midmem_reset: dmem_req=%b ir=%h state=%0d want 0/00000013/0", dmem_req, ir, state_dbg);
    end
    dmem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state_dbg !== ST_FETCH || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL midmem_late_ready: state=%0d dmem_req=%b want 0/0", state_dbg, dmem_req);
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_illegal();
    int req = 0, strobes = 0;
    run(32'hFFFF_FFFF, 0, 0, 32'd0, 32'd0);
    checks++;
    if (t_timeout || illegal !== 1'b1 || state_dbg !== ST_TRAP || count_of(0) != 0 || count_of(1) != 0) begin
      errors++;
      $display("FAIL illegal_trap: illegal=%b state=%0d pc_we=%0d reg_we=%0d want 1/5/0/0",
               illegal, state_dbg, count_of(0), count_of(1));
    end
    imem_rdata = 32'h0020_81B3;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req     += int'(imem_req) + int'(dmem_req);
      strobes += int'(pc_we) + int'(reg_we);
    end
    checks++;
    if (req != 0 || strobes != 0 || state_dbg !== ST_TRAP || illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_hold: reqs=%0d strobes=%0d state=%0d want 0/0/5", req, strobes, state_dbg);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift_imm();
    test_load();
    test_branch();
    test_x0();
    test_random();
    test_reset_mid_mem();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
